// File: rtl/dtlb_assoc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dtlb_assoc_pkg
// Description : Shared types and constants for the set-associative DTLB.
//               Holds the default parameter values, the sweep/run FSM state
//               encoding and the per-way entry record. Entry fields are sized
//               by the default widths; narrower instances zero-extend into
//               them.
// Revision    : 1.0 - initial release
// ============================================================================
package dtlb_assoc_pkg;

  localparam int WAYS_DEF   = 8;
  localparam int SETS_DEF   = 16;
  localparam int VPN_W_DEF  = 51;
  localparam int ASID_W_DEF = 21;
  localparam int DATA_W_DEF = 44;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  typedef struct packed {
    logic                  valid;
    logic                  is_global;
    logic [VPN_W_DEF-1:0]  tag;
    logic [ASID_W_DEF-1:0] asid;
    logic [DATA_W_DEF-1:0] data;
  } entry_t;

endpackage : dtlb_assoc_pkg
`default_nettype wire

// File: rtl/dtlb_assoc_if.sv
`default_nettype none
// ============================================================================
// Module      : dtlb_assoc_if
// Description : Lookup / write / flush bundle of the DTLB.
//               master : requester (drives rd_*, wr_*, force_*, flush_req)
//               slave  : DTLB (drives rd_valid/hit/way/data, flush_done, busy)
// Revision    : 1.0 - initial release
// ============================================================================
interface dtlb_assoc_if #(
  parameter int WAYS   = 8,
  parameter int VPN_W  = 51,
  parameter int ASID_W = 21,
  parameter int DATA_W = 44
);
  localparam int AW = $clog2(WAYS);

  logic              rd_en;
  logic [VPN_W-1:0]  rd_vpn;
  logic [ASID_W-1:0] rd_asid;
  logic              rd_valid;
  logic              rd_hit;
  logic [AW-1:0]     rd_way;
  logic [DATA_W-1:0] rd_data;

  logic              wr_en;
  logic              wr_invl;
  logic              wr_global;
  logic [VPN_W-1:0]  wr_vpn;
  logic [ASID_W-1:0] wr_asid;
  logic [DATA_W-1:0] wr_data;
  logic              force_way_en;
  logic [AW-1:0]     force_way;

  logic              flush_req;
  logic              flush_done;
  logic              busy;

  modport master (
    output rd_en, rd_vpn, rd_asid,
    output wr_en, wr_invl, wr_global, wr_vpn, wr_asid, wr_data,
    output force_way_en, force_way, flush_req,
    input  rd_valid, rd_hit, rd_way, rd_data, flush_done, busy
  );

  modport slave (
    input  rd_en, rd_vpn, rd_asid,
    input  wr_en, wr_invl, wr_global, wr_vpn, wr_asid, wr_data,
    input  force_way_en, force_way, flush_req,
    output rd_valid, rd_hit, rd_way, rd_data, flush_done, busy
  );

endinterface : dtlb_assoc_if
`default_nettype wire

// File: rtl/dtlb_assoc_lru.sv
`default_nettype none
// ============================================================================
// Module      : dtlb_assoc_lru
// Description : Age-based LRU for one set (purely combinational).
//               i_age       : current age per way (0 = most recent)
//               i_touch_way : way being made most recent
//               o_age       : ages after the touch
//               o_victim    : way whose current age is WAYS-1
// Revision    : 1.0 - initial release
// ============================================================================
module dtlb_assoc_lru #(
  parameter int WAYS = 8,
  localparam int AW  = $clog2(WAYS)
) (
  input  logic [WAYS-1:0][AW-1:0] i_age,
  input  logic [AW-1:0]           i_touch_way,
  output logic [WAYS-1:0][AW-1:0] o_age,
  output logic [AW-1:0]           o_victim
);

  logic [AW-1:0] w_old_age;
  assign w_old_age = i_age[i_touch_way];

  // Ages form a permutation of 0..WAYS-1; bumping only the younger ways
  // keeps it a permutation, so exactly one way always holds age WAYS-1.
  for (genvar g = 0; g < WAYS; g++) begin : g_age
    assign o_age[g] = (AW'(g) == i_touch_way) ? '0 :
                      (i_age[g] < w_old_age)  ? i_age[g] + 1'b1 :
                                                i_age[g];
  end

  always_comb begin
    o_victim = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (i_age[w] == AW'(WAYS - 1)) o_victim = AW'(w);
    end
  end

endmodule : dtlb_assoc_lru
`default_nettype wire

// File: rtl/dtlb_assoc.sv
`default_nettype none
// ============================================================================
// Module      : dtlb_assoc
// Description : Set-associative data TLB with per-set age LRU, forced-way
//               fills, invalidate and a one-set-per-cycle init/flush sweep.
//               clk, rst : clock, synchronous active-high reset
//               bus      : dtlb_assoc_if.slave (lookup, write, flush, status)
//               Optional : define DTLB_ASSOC_GLOBAL_EN to store the global
//                          bit; global entries then ignore the ASID compare.
// Revision    : 1.0 - initial release
// ============================================================================
module dtlb_assoc
  import dtlb_assoc_pkg::*;
#(
  parameter int WAYS   = WAYS_DEF,
  parameter int SETS   = SETS_DEF,
  parameter int VPN_W  = VPN_W_DEF,
  parameter int ASID_W = ASID_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic        clk,
  input  logic        rst,
  dtlb_assoc_if.slave bus
);

  localparam int AW = $clog2(WAYS);
  localparam int IW = $clog2(SETS);

  // Array has no reset: valid bits are cleared by the INIT sweep.
  entry_t                  r_mem [SETS][WAYS];
  logic [WAYS-1:0][AW-1:0] r_age [SETS];

  state_t            r_state;
  logic [IW-1:0]     r_sweep;
  logic              r_busy;
  logic              r_flush_done;
  logic              r_rd_valid;
  logic              r_rd_hit;
  logic [AW-1:0]     r_rd_way;
  logic [DATA_W-1:0] r_rd_data;

  logic                    w_rd_fire, w_wr_fire, w_fill, w_inval;
  logic                    w_rd_hit, w_wr_hit, w_wr_global;
  logic [AW-1:0]           w_rd_way, w_wr_hit_way, w_wr_way, w_victim;
  logic [AW-1:0]           w_rd_victim_unused;
  logic [WAYS-1:0][AW-1:0] w_rd_age_nxt, w_wr_age_nxt;
  logic [IW-1:0]           w_rd_set, w_wr_set;

  function automatic logic ent_match(entry_t e, logic [VPN_W-1:0] vpn,
                                     logic [ASID_W-1:0] asid);
    logic asid_ok;
    asid_ok = (e.asid == ASID_W_DEF'(asid));
`ifdef DTLB_ASSOC_GLOBAL_EN
    asid_ok = asid_ok | e.is_global;
`endif
    return e.valid && (e.tag == VPN_W_DEF'(vpn)) && asid_ok;
  endfunction

`ifdef DTLB_ASSOC_GLOBAL_EN
  assign w_wr_global = bus.wr_global;
`else
  logic w_unused_global;
  assign w_unused_global = bus.wr_global;
  assign w_wr_global     = 1'b0;
`endif

  assign w_rd_fire = bus.rd_en & ~r_busy;
  assign w_wr_fire = bus.wr_en & ~r_busy;
  assign w_fill    = w_wr_fire & ~bus.wr_invl;
  assign w_inval   = w_wr_fire &  bus.wr_invl;
  assign w_rd_set  = bus.rd_vpn[IW-1:0];
  assign w_wr_set  = bus.wr_vpn[IW-1:0];

  // Descending scan so the lowest matching way wins.
  always_comb begin
    w_rd_hit     = 1'b0;
    w_rd_way     = '0;
    w_wr_hit     = 1'b0;
    w_wr_hit_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (ent_match(r_mem[w_rd_set][w], bus.rd_vpn, bus.rd_asid)) begin
        w_rd_hit = 1'b1;
        w_rd_way = AW'(w);
      end
      if (ent_match(r_mem[w_wr_set][w], bus.wr_vpn, bus.wr_asid)) begin
        w_wr_hit     = 1'b1;
        w_wr_hit_way = AW'(w);
      end
    end
  end

  // Refill of an existing translation reuses its way, so no duplicates arise.
  assign w_wr_way = w_wr_hit         ? w_wr_hit_way  :
                    bus.force_way_en ? bus.force_way : w_victim;

  dtlb_assoc_lru #(.WAYS(WAYS)) u_lru_rd (
    .i_age       (r_age[w_rd_set]),
    .i_touch_way (w_rd_way),
    .o_age       (w_rd_age_nxt),
    .o_victim    (w_rd_victim_unused)
  );

  dtlb_assoc_lru #(.WAYS(WAYS)) u_lru_wr (
    .i_age       (r_age[w_wr_set]),
    .i_touch_way (w_wr_way),
    .o_age       (w_wr_age_nxt),
    .o_victim    (w_victim)
  );

  // Array and LRU storage
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (r_busy) begin
        for (int w = 0; w < WAYS; w++) begin
          r_mem[r_sweep][w].valid <= 1'b0;
          r_age[r_sweep][w]       <= AW'(w);
        end
      end else begin
        if (w_fill) begin
          r_mem[w_wr_set][w_wr_way] <= '{valid:     1'b1,
                                        is_global: w_wr_global,
                                        tag:       VPN_W_DEF'(bus.wr_vpn),
                                        asid:      ASID_W_DEF'(bus.wr_asid),
                                        data:      DATA_W_DEF'(bus.wr_data)};
          r_age[w_wr_set] <= w_wr_age_nxt;
        end else if (w_inval && w_wr_hit) begin
          r_mem[w_wr_set][w_wr_hit_way].valid <= 1'b0;
        end
        // A write to the same set owns that set's LRU this cycle.
        if (w_rd_fire && w_rd_hit && !(w_wr_fire && (w_wr_set == w_rd_set))) begin
          r_age[w_rd_set] <= w_rd_age_nxt;
        end
      end
    end
  end

  // Control FSM and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= INIT;
      r_sweep      <= '0;
      r_busy       <= 1'b1;
      r_flush_done <= 1'b0;
      r_rd_valid   <= 1'b0;
      r_rd_hit     <= 1'b0;
      r_rd_way     <= '0;
      r_rd_data    <= '0;
    end else begin
      r_flush_done <= 1'b0;
      r_rd_valid   <= w_rd_fire;
      r_rd_hit     <= w_rd_fire & w_rd_hit;
      r_rd_way     <= (w_rd_fire & w_rd_hit) ? w_rd_way : '0;
      r_rd_data    <= (w_rd_fire & w_rd_hit) ?
                      r_mem[w_rd_set][w_rd_way].data[DATA_W-1:0] : '0;
      case (r_state)
        INIT, FLUSH: begin
          r_sweep <= r_sweep + 1'b1;
          if (r_sweep == IW'(SETS - 1)) begin
            r_state      <= RUN;
            r_busy       <= 1'b0;
            r_flush_done <= (r_state == FLUSH);
          end
        end
        RUN: begin
          if (bus.flush_req) begin
            r_state <= FLUSH;
            r_sweep <= '0;
            r_busy  <= 1'b1;
          end
        end
        default: begin
          r_state <= INIT;
          r_sweep <= '0;
          r_busy  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.rd_valid   = r_rd_valid;
  assign bus.rd_hit     = r_rd_hit;
  assign bus.rd_way     = r_rd_way;
  assign bus.rd_data    = r_rd_data;
  assign bus.flush_done = r_flush_done;
  assign bus.busy       = r_busy;

endmodule : dtlb_assoc
`default_nettype wire

// File: tb/tb_dtlb_assoc.sv
`default_nettype none
// ============================================================================
// Module      : tb_dtlb_assoc
// Description : Directed scoreboard bench for dtlb_assoc (default parameters).
//               Lookups push their hand-computed result into a queue; a
//               monitor pops and compares on every rd_valid.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dtlb_assoc;

  localparam int WAYS = 8, SETS = 16, VPN_W = 51, ASID_W = 21, DATA_W = 44;
  localparam int AW = 3;

  typedef struct {
    logic              hit;
    logic [AW-1:0]     way;
    logic [DATA_W-1:0] data;
    string             name;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dtlb_assoc_if #(.WAYS(WAYS), .VPN_W(VPN_W), .ASID_W(ASID_W), .DATA_W(DATA_W)) bus ();

  dtlb_assoc #(.WAYS(WAYS), .SETS(SETS), .VPN_W(VPN_W), .ASID_W(ASID_W), .DATA_W(DATA_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t sb[$];
  exp_t e;
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Scoreboard monitor
  always @(posedge clk) begin
    #1;
    if (bus.rd_valid === 1'b1) begin
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_rd_valid: got rd_valid=1, expected no pending lookup");
      end else begin
        e = sb.pop_front();
        if (bus.rd_hit !== e.hit || bus.rd_way !== e.way || bus.rd_data !== e.data) begin
          n_fail++;
          $display("FAIL %s: got hit=%0b way=%0d data=0x%0h, expected hit=%0b way=%0d data=0x%0h",
                   e.name, bus.rd_hit, bus.rd_way, bus.rd_data, e.hit, e.way, e.data);
        end
      end
    end
  end

  task automatic idle_inputs();
    bus.rd_en = 1'b0; bus.rd_vpn = '0; bus.rd_asid = '0;
    bus.wr_en = 1'b0; bus.wr_invl = 1'b0; bus.wr_global = 1'b0;
    bus.wr_vpn = '0; bus.wr_asid = '0; bus.wr_data = '0;
    bus.force_way_en = 1'b0; bus.force_way = '0; bus.flush_req = 1'b0;
  endtask

  task automatic drv_rd(input logic [VPN_W-1:0] vpn, input logic [ASID_W-1:0] asid,
                        input logic hit, input logic [AW-1:0] way,
                        input logic [DATA_W-1:0] data, input string name);
    exp_t x;
    bus.rd_en = 1'b1; bus.rd_vpn = vpn; bus.rd_asid = asid;
    x.hit = hit; x.way = way; x.data = data; x.name = name;
    sb.push_back(x);
  endtask

  task automatic drv_wr(input logic [VPN_W-1:0] vpn, input logic [ASID_W-1:0] asid,
                        input logic [DATA_W-1:0] data, input logic invl, input logic glob,
                        input logic fen, input logic [AW-1:0] fway);
    bus.wr_en = 1'b1; bus.wr_invl = invl; bus.wr_global = glob;
    bus.wr_vpn = vpn; bus.wr_asid = asid; bus.wr_data = data;
    bus.force_way_en = fen; bus.force_way = fway;
  endtask

  task automatic step();
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic lookup(input logic [VPN_W-1:0] vpn, input logic [ASID_W-1:0] asid,
                        input logic hit, input logic [AW-1:0] way,
                        input logic [DATA_W-1:0] data, input string name);
    drv_rd(vpn, asid, hit, way, data, name);
    step();
  endtask

  task automatic fill(input logic [VPN_W-1:0] vpn, input logic [ASID_W-1:0] asid,
                      input logic [DATA_W-1:0] data);
    drv_wr(vpn, asid, data, 1'b0, 1'b0, 1'b0, '0);
    step();
  endtask

  // Counts clock edges until busy drops, bounded; also reports any flush_done.
  task automatic count_busy(output int cnt, output bit saw_done);
    cnt = 0; saw_done = 1'b0;
    while (bus.busy === 1'b1 && cnt < 100) begin
      @(posedge clk); #1;
      cnt++;
      if (bus.flush_done === 1'b1) saw_done = 1'b1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, expected bench completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cnt;
    bit seen, seen2;
    logic glob_hit;

    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_rd_valid",   64'(bus.rd_valid),   0);
    check("rst_rd_hit",     64'(bus.rd_hit),     0);
    check("rst_rd_way",     64'(bus.rd_way),     0);
    check("rst_rd_data",    64'(bus.rd_data),    0);
    check("rst_flush_done", 64'(bus.flush_done), 0);
    check("rst_busy",       64'(bus.busy),       1);
    count_busy(cnt, seen);
    check("init_busy_cycles", 64'(cnt), 16);
    @(negedge clk);

    lookup(51'h77, 21'd0, 1'b0, 3'd0, '0, "empty_miss");

    // Nine fills into set 3: way 7 first, then 6..0, ninth evicts way 7.
    for (int i = 1; i <= 9; i++) fill(51'(i * 16 + 3), 21'd2, 44'(32'h100 + i));
    lookup(51'h13, 21'd2, 1'b0, 3'd0, '0,       "evicted_first_miss");
    lookup(51'h23, 21'd2, 1'b1, 3'd6, 44'h102,  "second_fill_hit");
    lookup(51'h93, 21'd2, 1'b1, 3'd7, 44'h109,  "ninth_fill_way7");

    // Set 10: a hit on the oldest way makes the next-oldest the victim.
    for (int i = 1; i <= 8; i++) fill(51'(i * 16 + 10), 21'd2, 44'(32'h200 + i));
    lookup(51'h1A, 21'd2, 1'b1, 3'd7, 44'h201, "touch_oldest_hit");
    fill(51'h9A, 21'd2, 44'h209);
    lookup(51'h2A, 21'd2, 1'b0, 3'd0, '0,      "lru_victim_miss");
    lookup(51'h1A, 21'd2, 1'b1, 3'd7, 44'h201, "touched_survives");
    lookup(51'h9A, 21'd2, 1'b1, 3'd6, 44'h209, "refill_way6");

    // Flush after four fills
    for (int i = 0; i < 4; i++) fill(51'(32'h200 + i), 21'd1, 44'(32'h2000 + i));
    lookup(51'h200, 21'd1, 1'b1, 3'd7, 44'h2000, "pre_flush_hit");
    bus.flush_req = 1'b1;
    @(posedge clk); #1;
    check("flush_busy", 64'(bus.busy), 1);
    bus.flush_req = 1'b0;
    bus.rd_en = 1'b1; bus.rd_vpn = 51'h200; bus.rd_asid = 21'd1;  // ignored while busy
    cnt = 0; seen = 1'b0;
    while (!seen && cnt < 40) begin
      @(posedge clk); #1;
      cnt++;
      idle_inputs();
      if (bus.flush_done === 1'b1) seen = 1'b1;
    end
    check("flush_done_latency", 64'(cnt), 16);
    @(posedge clk); #1;
    check("flush_done_pulse", 64'(bus.flush_done), 0);
    check("flush_busy_clear", 64'(bus.busy), 0);
    @(negedge clk);
    for (int i = 0; i < 4; i++) lookup(51'(32'h200 + i), 21'd1, 1'b0, 3'd0, '0, "post_flush_miss");

    // Fill + same-cycle lookup sees pre-write contents
    drv_wr(51'h123, 21'd5, 44'hABC, 1'b0, 1'b0, 1'b0, '0);
    drv_rd(51'h123, 21'd5, 1'b0, 3'd0, '0, "same_cycle_prewrite");
    step();
    lookup(51'h123, 21'd5, 1'b1, 3'd7, 44'hABC, "fill_hit");
    lookup(51'h123, 21'd6, 1'b0, 3'd0, '0,      "asid_mismatch_miss");

    // Forced way, refill in place, invalidate
    drv_wr(51'h456, 21'd3, 44'h111, 1'b0, 1'b0, 1'b1, 3'd2);
    step();
    lookup(51'h456, 21'd3, 1'b1, 3'd2, 44'h111, "forced_way2");
    fill(51'h456, 21'd3, 44'h222);
    lookup(51'h456, 21'd3, 1'b1, 3'd2, 44'h222, "refill_same_way");
    drv_wr(51'h456, 21'd3, '0, 1'b1, 1'b0, 1'b0, '0);
    step();
    lookup(51'h456, 21'd3, 1'b0, 3'd0, '0, "invalidated_no_dup");
    drv_wr(51'h123, 21'd9, '0, 1'b1, 1'b0, 1'b0, '0);
    step();
    lookup(51'h123, 21'd5, 1'b1, 3'd7, 44'hABC, "inval_miss_no_effect");

    // Reset in the middle of a flush
    bus.flush_req = 1'b1;
    @(posedge clk); #1;
    bus.flush_req = 1'b0;
    seen = 1'b0;
    repeat (7) begin
      @(posedge clk); #1;
      if (bus.flush_done === 1'b1) seen = 1'b1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_mid_flush_busy", 64'(bus.busy), 1);
    count_busy(cnt, seen2);
    check("rst_mid_flush_cycles", 64'(cnt), 16);
    check("rst_mid_flush_no_done", 64'(seen | seen2), 0);
    @(negedge clk);

    // Global entry looked up under a different ASID
`ifdef DTLB_ASSOC_GLOBAL_EN
    glob_hit = 1'b1;
`else
    glob_hit = 1'b0;
`endif
    drv_wr(51'h777, 21'd1, 44'h5A5, 1'b0, 1'b1, 1'b0, '0);
    step();
    lookup(51'h777, 21'd9, glob_hit, glob_hit ? 3'd7 : 3'd0, glob_hit ? 44'h5A5 : 44'h0, "global_other_asid");
    lookup(51'h777, 21'd1, 1'b1, 3'd7, 44'h5A5, "global_own_asid");

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", 64'(sb.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_dtlb_assoc
`default_nettype wire

// File: doc/dtlb_assoc.md
DTLB_ASSOC -- requirements
Module: dtlb_assoc

Interface
REQ-001 The block SHALL have parameter WAYS, default 8, associativity; power of 2, range 2..16.
REQ-002 The block SHALL have parameter SETS, default 16, set count; power of 2, range 4..64.
REQ-003 The block SHALL have parameter VPN_W, default 51, virtual page number width.
REQ-004 The block SHALL have parameter ASID_W, default 21, address-space id width.
REQ-005 The block SHALL have parameter DATA_W, default 44, translation payload width.
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-007 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-008 The block SHALL have port rd_en, input, 1 bit: lookup request.
REQ-009 The block SHALL have port rd_vpn, input, VPN_W bits: lookup VPN; the low log2(SETS) bits are the set index.
REQ-010 The block SHALL have port rd_asid, input, ASID_W bits: lookup ASID.
REQ-011 The block SHALL have output rd_valid, 1 bit: lookup result valid.
REQ-012 The block SHALL have outputs rd_hit, 1 bit; rd_way, log2(WAYS) bits; rd_data, DATA_W bits.
REQ-013 The block SHALL have inputs wr_en, wr_invl, wr_global (1 bit each); wr_vpn (VPN_W); wr_asid (ASID_W); wr_data (DATA_W).
REQ-014 The block SHALL have inputs force_way_en, 1 bit, and force_way, log2(WAYS) bits.
REQ-015 The block SHALL have input flush_req, 1 bit, and outputs flush_done, 1 bit, and busy, 1 bit.

Function
REQ-016 The FSM SHALL have states INIT, RUN and FLUSH; rst SHALL enter INIT with the sweep counter at 0.
REQ-017 INIT and FLUSH SHALL each clear valid and reset LRU ages (way w gets age w) for one set per cycle, taking SETS cycles.
REQ-018 After set SETS-1, INIT and FLUSH SHALL go to RUN; leaving FLUSH SHALL pulse flush_done for one cycle.
REQ-019 busy SHALL be 1 in INIT and FLUSH; rd_en, wr_en and flush_req SHALL be ignored while busy.
REQ-020 flush_req in RUN SHALL enter FLUSH next cycle; a wr_en in that same cycle SHALL complete first.
REQ-021 Lookup latency SHALL be 1 cycle: rd_valid, rd_hit, rd_way and rd_data are registered, and rd_valid is the registered value of rd_en & ~busy.
REQ-022 A way SHALL hit when valid & tag==rd_vpn & asid==rd_asid.
REQ-023 On a miss, rd_hit SHALL be 0 and rd_way and rd_data SHALL be 0; at most one way hits (the filler guarantees this), otherwise the lowest index is taken.
REQ-024 The LRU state SHALL be one log2(WAYS)-bit age per way per set.
REQ-025 Touching a way SHALL set its age to 0 and increment the ages smaller than its old age; other ages SHALL hold.
REQ-026 A lookup hit SHALL touch the hit way.
REQ-027 A fill (wr_en, ~wr_invl) SHALL first select a way: an existing way matching wr_vpn/wr_asid, else force_way if force_way_en, else the way with age WAYS-1.
REQ-028 The fill SHALL then write valid=1, tag, asid, global, data into that way and touch it.
REQ-029 An invalidate (wr_en & wr_invl) SHALL clear valid in the matching way only, with no LRU change and no effect on a miss.
REQ-030 Writes SHALL take effect at the clock edge; a lookup in the same cycle to the same set SHALL see pre-write contents.
REQ-031 When a lookup and a write hit the same set in one cycle, only the write's LRU update SHALL apply.
REQ-032 rst asserted mid-FLUSH SHALL abort the flush without flush_done and restart INIT.

Reset
REQ-033 In the cycle after rst: rd_valid=0, rd_hit=0, rd_way=0, rd_data=0, flush_done=0, busy=1.
REQ-034 Array contents SHALL be undefined until INIT completes; INIT SHALL complete exactly SETS cycles after rst deasserts.

Configuration
REQ-035 Macro DTLB_ASSOC_GLOBAL_EN defined: a way with global=1 SHALL hit regardless of rd_asid, and invalidate SHALL also match on global.
REQ-036 Macro DTLB_ASSOC_GLOBAL_EN undefined: the global bit SHALL not be stored and wr_global SHALL be ignored (strict ASID match).

Structure
REQ-037 A shared package SHALL hold the entry struct (valid, global, tag, asid, data), the FSM state enum and the default parameter constants.
REQ-038 One sub-module, dtlb_assoc_lru, SHALL implement the per-set age update and victim selection, parameterised by WAYS.
REQ-039 The tag/data array SHALL be plain registers with synchronous write and asynchronous read.

Verification
REQ-040 rst high 1 cycle, defaults -> busy=1 for exactly 16 cycles, then 0; rd_en with any VPN -> rd_valid=1, rd_hit=0.
REQ-041 Fill VPN 0x123 ASID 5 data 0xABC, then look up VPN 0x123 ASID 5 -> rd_hit=1 and rd_data=0xABC one cycle later; ASID 6 -> miss.
REQ-042 Nine fills to set 3 with distinct VPNs and no lookups -> the ninth evicts the first (way 7 at first fill); lookup of the first VPN misses.
REQ-043 force_way_en=1, force_way=2, fill -> rd_way=2 on a subsequent hit; re-fill of the same VPN without force -> same way is updated, not duplicated.
REQ-044 flush_req after 4 fills -> flush_done pulses 16 cycles later and all 4 lookups miss; a second rst at sweep count 7 -> no flush_done and busy for 16 more cycles.
REQ-045 With DTLB_ASSOC_GLOBAL_EN: fill wr_global=1 ASID 1, look up ASID 9 -> hit; without the macro -> miss.
